uart_byte_tx: RTL and testbench
===============================

Name: uart_byte_tx

Overview:
UART transmitter serializing one byte per request onto a single TX line in 8N1 format: 1 start bit, 8 data bits LSB first, 1 stop bit, no parity. Bit rate is selected at run time from five standard baud rates derived from the system clock. Sits between a byte-producing controller and the board-level RS-232 pin. Reports busy status and a one-cycle completion strobe.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz; all baud divisors are derived from it.

Ports:
clk  input  1  system clock; all logic on rising edge.
Rst_n  input  1  reset, asynchronous, active-high. The port keeps the codebase name Rst_n; asserted = 1.
data_byte  input  8  byte to transmit; sampled only on an accepted request.
send_en  input  1  transmit request; single-cycle pulse, level-sampled each clock.
baud_set  input  3  baud select: 0=9600, 1=19200, 2=38400, 3=57600, 4=115200; 5..7 = 9600.
Rs232_Tx  output  1  serial line; idles high.
Tx_Done  output  1  one-cycle pulse when a frame's stop bit completes.
uart_state  output  1  1 while a frame is in progress, 0 when idle.

Behaviour:
- Reset (async assert): Rs232_Tx=1, Tx_Done=0, uart_state=0. Counters and latched byte are cleared. Any frame in progress is aborted immediately, and the line returns to idle-high.
- Divisor DIV = CLK_FREQ/baud, rounded to nearest. At 50 MHz: 5208, 2604, 1302, 868, 434 clocks per bit.
- States: IDLE and BUSY; uart_state = (state==BUSY).
- IDLE: if send_en=1 at rising edge k, latch data_byte and the DIV implied by baud_set, then enter BUSY at k+1.
- Frame bits: bit index b runs 0..9. b=0 is start (0), b=1..8 are data[b-1], b=9 is stop (1).
- Bit b drives Rs232_Tx during cycles k+1+b*DIV through k+(b+1)*DIV. Each bit lasts exactly DIV clocks.
- End of frame: at cycle k+1+10*DIV, Tx_Done=1 for exactly one cycle, uart_state=0, and Rs232_Tx=1.
- Latency: request to first start-bit cycle = 1 clock. Request to Tx_Done = 10*DIV+1 clocks (4341 at 115200).
- send_en while BUSY, including the Tx_Done cycle: ignored, no queuing. A new request is accepted from the cycle after Tx_Done.
- data_byte or baud_set changes during BUSY: no effect on the current frame.
- send_en held high continuously: one frame per acceptance, back-to-back, with one idle cycle between frames.
- Divisor counter width: 13 bits, sufficient for 5208.

Decomposition:
- Package uart_pkg: baud-select constants (BAUD_9600..BAUD_115200), a function or constant array mapping baud_set to DIV given CLK_FREQ, and frame constants (DATA_BITS=8, FRAME_BITS=10).
- One sub-module, uart_baud_tick: divisor counter producing a one-cycle bit tick every DIV clocks. It is enabled and cleared by the FSM.
- The FSM and shift/bit counter stay in uart_byte_tx.

Test Plan:
- Reset held, then released: Rs232_Tx=1, uart_state=0, Tx_Done=0 throughout. Assert reset mid-frame: outputs return to reset values within the same cycle.
- baud_set=4, data_byte=8'hAA with a 1-cycle send_en: the line carries 0,0,1,0,1,0,1,0,1,1 (start, LSB first, stop), each bit 434 clocks. Tx_Done pulses once, 4341 clocks after the request; uart_state is high 4340 cycles.
- After Tx_Done plus idle time, send 8'h55 at baud_set=4: the line carries 0,1,0,1,0,1,0,1,0,1. Exactly one Tx_Done pulse.
- Repeat 8'hAA at baud_set=0 and baud_set=3: bit widths are 5208 and 868 clocks respectively. baud_set=7 behaves as 9600.
- Pulse send_en with 8'hFF mid-frame: the current frame is unchanged and no extra frame is sent. Change data_byte mid-frame: the transmitted bits are unchanged.
- Hold send_en=1 for two frames at baud_set=4: two identical frames, Tx_Done pulses 4341 clocks apart, with one idle-high cycle between stop bit and next start bit.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the byte-wide UART transmitter: baud-select codes,
// frame geometry and the clock-to-divisor helper.
package uart_pkg;

    // Baud select codes on baud_set; codes 5..7 fall back to 9600.
    localparam logic [2:0] BAUD_9600   = 3'd0;
    localparam logic [2:0] BAUD_19200  = 3'd1;
    localparam logic [2:0] BAUD_38400  = 3'd2;
    localparam logic [2:0] BAUD_57600  = 3'd3;
    localparam logic [2:0] BAUD_115200 = 3'd4;

    // Frame geometry: start + 8 data + stop.
    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    // 13 bits hold the slowest divisor (5208 at 50 MHz / 9600).
    localparam int DIV_W = 13;
    // Bit index counter covers 0..FRAME_BITS-1.
    localparam int BIT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } tx_state_e;

    // Clocks per bit, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud);
        return (clk_freq + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_byte_tx_baud_tick.sv
// Divisor counter: emits a one-cycle tick on the last clock of every bit
// period while enabled; held at zero while cleared.
import uart_pkg::*;

module uart_baud_tick (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt_q;
    logic             last;

    assign last = (cnt_q == div - {{(DIV_W-1){1'b0}}, 1'b1});
    assign tick = en && last;

    // Count clocks within the current bit; wrap at div-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            if (last) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_byte_tx.sv
// 8N1 UART transmitter. A request in IDLE latches the byte and the bit
// divisor; the frame then runs from the latched copies, so input changes
// during a frame have no effect.
//
// Handshake: send_en is level-sampled on each rising edge; it is accepted
// only when the FSM is IDLE, and ignored (not queued) while BUSY. Tx_Done
// is a one-cycle strobe registered at the end of the stop bit; the FSM is
// already IDLE in that cycle, so a held send_en starts the next frame with
// exactly one idle-high cycle between frames. uart_state mirrors the FSM.
import uart_pkg::*;

module uart_byte_tx #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clk,
    input  logic       Rst_n,
    input  logic [7:0] data_byte,
    input  logic       send_en,
    input  logic [2:0] baud_set,
    output logic       Rs232_Tx,
    output logic       Tx_Done,
    output logic       uart_state
);

    localparam logic [DIV_W-1:0] DIV_9600   = DIV_W'(calc_div(CLK_FREQ, 9600));
    localparam logic [DIV_W-1:0] DIV_19200  = DIV_W'(calc_div(CLK_FREQ, 19200));
    localparam logic [DIV_W-1:0] DIV_38400  = DIV_W'(calc_div(CLK_FREQ, 38400));
    localparam logic [DIV_W-1:0] DIV_57600  = DIV_W'(calc_div(CLK_FREQ, 57600));
    localparam logic [DIV_W-1:0] DIV_115200 = DIV_W'(calc_div(CLK_FREQ, 115200));

    localparam logic [BIT_W-1:0] STOP_IDX = BIT_W'(FRAME_BITS - 1);
    localparam logic [BIT_W-1:0] LAST_DATA_IDX = BIT_W'(DATA_BITS);

    tx_state_e        state_q, state_d;
    logic             tx_q, tx_d;
    logic             done_q, done_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [7:0]       shift_q, shift_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] sel_div;
    logic             bit_tick;

    assign Rs232_Tx   = tx_q;
    assign Tx_Done    = done_q;
    assign uart_state = (state_q == ST_BUSY);

    // Map the baud select code to clocks per bit.
    always_comb begin
        sel_div = DIV_9600;
        case (baud_set)
            BAUD_19200:  sel_div = DIV_19200;
            BAUD_38400:  sel_div = DIV_38400;
            BAUD_57600:  sel_div = DIV_57600;
            BAUD_115200: sel_div = DIV_115200;
            default:     sel_div = DIV_9600;
        endcase
    end

    uart_baud_tick u_tick (
        .clk  (clk),
        .rst  (Rst_n),
        .en   (state_q == ST_BUSY),
        .clr  (state_q == ST_IDLE),
        .div  (div_q),
        .tick (bit_tick)
    );

    // Next-state and datapath: accept in IDLE, advance one bit per tick in BUSY.
    always_comb begin
        state_d = state_q;
        tx_d    = tx_q;
        done_d  = 1'b0;
        bit_d   = bit_q;
        shift_d = shift_q;
        div_d   = div_q;
        case (state_q)
            ST_IDLE: begin
                tx_d = 1'b1;
                if (send_en) begin
                    state_d = ST_BUSY;
                    tx_d    = 1'b0;
                    bit_d   = '0;
                    shift_d = data_byte;
                    div_d   = sel_div;
                end
            end
            ST_BUSY: begin
                if (bit_tick) begin
                    if (bit_q == STOP_IDX) begin
                        state_d = ST_IDLE;
                        tx_d    = 1'b1;
                        done_d  = 1'b1;
                        bit_d   = '0;
                    end else if (bit_q == LAST_DATA_IDX) begin
                        tx_d  = 1'b1;
                        bit_d = bit_q + {{(BIT_W-1){1'b0}}, 1'b1};
                    end else begin
                        tx_d    = shift_q[0];
                        shift_d = {1'b0, shift_q[7:1]};
                        bit_d   = bit_q + {{(BIT_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

    // State and datapath registers; reset aborts any frame and idles the line.
    always_ff @(posedge clk or posedge Rst_n) begin
        if (Rst_n) begin
            state_q <= ST_IDLE;
            tx_q    <= 1'b1;
            done_q  <= 1'b0;
            bit_q   <= '0;
            shift_q <= '0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: tb/tb_uart_byte_tx.sv
// Bench for uart_byte_tx: randomized frames checked against a waveform
// model built from frame rules (bit b held for DIV samples, Tx_Done after).
module tb_uart_byte_tx;

    logic       clk;
    logic       Rst_n;
    logic [7:0] data_byte;
    logic       send_en;
    logic [2:0] baud_set;
    logic       Rs232_Tx;
    logic       Tx_Done;
    logic       uart_state;

    int checks;
    int failures;

    uart_byte_tx #(.CLK_FREQ(50_000_000)) dut (
        .clk        (clk),
        .Rst_n      (Rst_n),
        .data_byte  (data_byte),
        .send_en    (send_en),
        .baud_set   (baud_set),
        .Rs232_Tx   (Rs232_Tx),
        .Tx_Done    (Tx_Done),
        .uart_state (uart_state)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks per bit at 50 MHz for each select code.
    function automatic int ref_div(input logic [2:0] sel);
        case (sel)
            3'd1:    return 2604;
            3'd2:    return 1302;
            3'd3:    return 868;
            3'd4:    return 434;
            default: return 5208;
        endcase
    endfunction

    // Observe idle for n samples: line high, not busy, no strobe.
    task automatic check_idle(input int n, input string name);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (Rs232_Tx !== 1'b1 || uart_state !== 1'b0 || Tx_Done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL %s: %0d non-idle samples, required 0", name, bad);
        end
    endtask

    // Issue a request and check nfr frames sample by sample against the model.
    // limit>0 stops observation early (mid-frame); pert_at injects a send_en
    // pulse with 8'hFF and a random baud_set at that sample.
    task automatic run_frames(input logic [7:0] d, input logic [2:0] sel, input int nfr,
                              input logic hold, input int limit, input int pert_at,
                              input string name);
        int div, per, total, pos, b;
        int line_err, st_err, dn_err, first_bad;
        int done_cnt, first_done, busy_cnt, first_high, exp_high;
        logic exp_tx, exp_st, exp_dn;
        logic [9:0] frame, mid_vec;
        div = ref_div(sel);
        per = 10 * div + 1;
        total = (limit > 0) ? limit : nfr * per;
        frame = {1'b1, d, 1'b0};
        mid_vec = '0;
        line_err = 0; st_err = 0; dn_err = 0; first_bad = -1;
        done_cnt = 0; first_done = -1; busy_cnt = 0; first_high = -1;
        b = 0;
        @(posedge clk); #1;
        data_byte = d; baud_set = sel; send_en = 1'b1;
        @(posedge clk); #1;
        if (!hold) send_en = 1'b0;
        for (int s = 1; s <= total; s++) begin
            @(negedge clk);
            pos = (s - 1) % per + 1;
            if (pos <= 10 * div) begin
                b = (pos - 1) / div;
                exp_tx = frame[b]; exp_st = 1'b1; exp_dn = 1'b0;
            end else begin
                exp_tx = 1'b1; exp_st = 1'b0; exp_dn = 1'b1;
            end
            if (Rs232_Tx !== exp_tx) begin line_err++; if (first_bad < 0) first_bad = s; end
            if (uart_state !== exp_st) st_err++;
            if (Tx_Done !== exp_dn) dn_err++;
            if (Tx_Done === 1'b1) begin done_cnt++; if (first_done < 0) first_done = s; end
            if (uart_state === 1'b1) busy_cnt++;
            if (Rs232_Tx === 1'b1 && first_high < 0) first_high = s;
            if (s <= per && pos <= 10 * div && ((pos - 1) % div) == div / 2) mid_vec[b] = Rs232_Tx;
            if (s < total) begin
                @(posedge clk); #1;
                if (s == pert_at) begin
                    send_en = 1'b1; data_byte = 8'hFF; baud_set = 3'($urandom_range(0, 7));
                end else if (s == pert_at + 1) begin
                    send_en = 1'b0;
                end
            end
        end
        if (hold) send_en = 1'b0;
        checks++;
        if (line_err !== 0) begin
            failures++;
            $display("FAIL %s line: %0d wrong samples (first at %0d), required 0", name, line_err, first_bad);
        end
        checks++;
        if (st_err !== 0) begin
            failures++;
            $display("FAIL %s uart_state: %0d wrong samples, required 0", name, st_err);
        end
        checks++;
        if (dn_err !== 0) begin
            failures++;
            $display("FAIL %s Tx_Done: %0d wrong samples, required 0", name, dn_err);
        end
        if (limit == 0) begin
            checks++;
            if (mid_vec !== frame) begin
                failures++;
                $display("FAIL %s bits: got %b, required %b", name, mid_vec, frame);
            end
            checks++;
            if (first_done !== 10 * div + 1) begin
                failures++;
                $display("FAIL %s done latency: got %0d, required %0d", name, first_done, 10 * div + 1);
            end
            checks++;
            if (done_cnt !== nfr) begin
                failures++;
                $display("FAIL %s done count: got %0d, required %0d", name, done_cnt, nfr);
            end
            checks++;
            if (busy_cnt !== nfr * 10 * div) begin
                failures++;
                $display("FAIL %s busy cycles: got %0d, required %0d", name, busy_cnt, nfr * 10 * div);
            end
        end else begin
            exp_high = -1;
            for (int i = 0; i < 10; i++) begin
                if (exp_high < 0 && frame[i] && i * div < total) exp_high = i * div + 1;
            end
            checks++;
            if (first_high !== exp_high) begin
                failures++;
                $display("FAIL %s first high sample: got %0d, required %0d", name, first_high, exp_high);
            end
        end
    endtask

    task automatic test_reset();
        int bad;
        bad = 0;
        Rst_n = 1'b1; send_en = 1'b0; data_byte = 8'h00; baud_set = 3'd4;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (Rs232_Tx !== 1'b1 || uart_state !== 1'b0 || Tx_Done !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_hold: %0d bad samples, required 0", bad);
        end
        Rst_n = 1'b0;
        check_idle(10, "reset_release");
    endtask

    // Assert reset asynchronously mid-frame; outputs must recover before the next edge.
    task automatic test_reset_mid_frame(input string name);
        #2 Rst_n = 1'b1;
        #1;
        checks++;
        if (Rs232_Tx !== 1'b1) begin
            failures++;
            $display("FAIL %s tx: got %b, required 1", name, Rs232_Tx);
        end
        checks++;
        if (uart_state !== 1'b0) begin
            failures++;
            $display("FAIL %s uart_state: got %b, required 0", name, uart_state);
        end
        checks++;
        if (Tx_Done !== 1'b0) begin
            failures++;
            $display("FAIL %s Tx_Done: got %b, required 0", name, Tx_Done);
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        Rst_n = 1'b0;
        check_idle(20, {name, "_idle"});
    endtask

    task automatic test_frame_aa_115200();
        run_frames(8'hAA, 3'd4, 1, 1'b0, 0, -5, "aa_115200");
        check_idle(20, "aa_115200_idle");
    endtask

    task automatic test_frame_55_115200();
        check_idle(30, "pre_55_idle");
        run_frames(8'h55, 3'd4, 1, 1'b0, 0, -5, "55_115200");
        check_idle(20, "55_115200_idle");
    endtask

    task automatic test_baud_57600();
        run_frames(8'hAA, 3'd3, 1, 1'b0, 0, -5, "aa_57600");
        check_idle(10, "aa_57600_idle");
    endtask

    task automatic test_baud_9600_and_7();
        run_frames(8'hAA, 3'd0, 1, 1'b0, 2 * 5208 + 2604, -5, "aa_9600_partial");
        test_reset_mid_frame("reset_mid_9600");
        run_frames(8'hAA, 3'd7, 1, 1'b0, 2 * 5208 + 2604, -5, "aa_sel7_partial");
        test_reset_mid_frame("reset_mid_sel7");
    endtask

    task automatic test_ignore_mid_frame();
        logic [7:0] d;
        d = 8'($urandom_range(0, 255));
        run_frames(d, 3'd4, 1, 1'b0, 0, 1500, "ignore_mid_frame");
        check_idle(100, "ignore_mid_frame_idle");
    endtask

    task automatic test_back_to_back();
        run_frames(8'hAA, 3'd4, 2, 1'b1, 0, -5, "back_to_back");
        check_idle(30, "back_to_back_idle");
    endtask

    task automatic test_random_frames();
        logic [7:0] d;
        for (int i = 0; i < 3; i++) begin
            d = 8'($urandom_range(0, 255));
            run_frames(d, 3'd4, 1, 1'b0, 0, -5, "random_frame");
            check_idle(int'($urandom_range(2, 20)), "random_idle");
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_frame_aa_115200();
        test_frame_55_115200();
        test_baud_57600();
        test_baud_9600_and_7();
        test_ignore_mid_frame();
        test_back_to_back();
        test_random_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
